// File: rtl/evo_circuit_tester_if.sv
`default_nettype none
// ============================================================================
// Module      : evo_circuit_tester_if
// Description : Bundle of host and circuit-under-test signals for
//               evo_circuit_tester.
//               slave  : the tester (consumes start/expected_tt/dut_out)
//               master : the host/bench side (drives start/expected_tt/dut_out)
// Signals     : start, expected_tt[V], dut_in[N_INPUTS], dut_out, busy, done,
//               error_count[clog2(REPEATS*V+1)], result_tt[V], unstable_mask[V]
// Revision    : 1.0 - initial release
// ============================================================================
interface evo_circuit_tester_if #(
    parameter int N_INPUTS = 3,
    parameter int REPEATS  = 2
);
    localparam int V  = 2 ** N_INPUTS;
    localparam int EW = $clog2(REPEATS * V + 1);

    logic                start;
    logic [V-1:0]        expected_tt;
    logic [N_INPUTS-1:0] dut_in;
    logic                dut_out;
    logic                busy;
    logic                done;
    logic [EW-1:0]       error_count;
    logic [V-1:0]        result_tt;
    logic [V-1:0]        unstable_mask;

    modport slave (
        input  start, expected_tt, dut_out,
        output dut_in, busy, done, error_count, result_tt, unstable_mask
    );

    modport master (
        output start, expected_tt, dut_out,
        input  dut_in, busy, done, error_count, result_tt, unstable_mask
    );
endinterface
`default_nettype wire

// File: rtl/evo_circuit_tester.sv
`default_nettype none
// ============================================================================
// Module      : evo_circuit_tester
// Description : Sequencer that sweeps every input vector of an evolved
//               combinational circuit, waits a settle time, samples its
//               (2-flop synchronized) output and scores it against a target
//               truth table over REPEATS passes.
// Ports       : clk    - clock
//               reset  - asynchronous active-high reset
//               bus    - evo_circuit_tester_if.slave (start, expected_tt,
//                        dut_in, dut_out, busy, done, error_count,
//                        result_tt, unstable_mask)
// Options     : EVO_TESTER_UNSTABLE_EN - when defined, unstable_mask flags
//               vectors whose output differs from the repeat-0 sample;
//               otherwise unstable_mask is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module evo_circuit_tester #(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int REPEATS       = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    evo_circuit_tester_if.slave   bus
);
    localparam int V  = 2 ** N_INPUTS;
    localparam int EW = $clog2(REPEATS * V + 1);
    localparam int RW = $clog2(REPEATS + 1);

    localparam logic [N_INPUTS-1:0] c_V_LAST = N_INPUTS'(V - 1);
    localparam logic [RW-1:0]       c_R_LAST = RW'(REPEATS - 1);
    localparam logic [7:0]          c_SETTLE = 8'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_sync;
    logic [V-1:0]        r_exp;
    logic [N_INPUTS-1:0] r_v;
    logic [RW-1:0]       r_r;
    logic [7:0]          r_cnt;
    logic [N_INPUTS-1:0] r_dut_in;
    logic                r_busy;
    logic                r_done;
    logic [EW-1:0]       r_err;
    logic [V-1:0]        r_result;
`ifdef EVO_TESTER_UNSTABLE_EN
    logic [V-1:0]        r_unstable;
`endif

    logic                w_s;
    assign w_s = r_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sync     <= '0;
            r_exp      <= '0;
            r_v        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            r_dut_in   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= '0;
            r_result   <= '0;
`ifdef EVO_TESTER_UNSTABLE_EN
            r_unstable <= '0;
`endif
        end else begin
            r_sync <= {r_sync[0], bus.dut_out};
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Table is latched so host-side changes mid-run are invisible.
                        r_exp      <= bus.expected_tt;
                        r_err      <= '0;
                        r_result   <= '0;
`ifdef EVO_TESTER_UNSTABLE_EN
                        r_unstable <= '0;
`endif
                        r_v        <= '0;
                        r_r        <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    r_dut_in <= r_v;
                    r_cnt    <= c_SETTLE;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Stays here exactly SETTLE_CYCLES cycles; the two
                    // synchronizer stages fill during this window.
                    if (r_cnt == 8'd1) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (w_s != r_exp[r_v]) begin
                        r_err <= r_err + EW'(1);
                    end
                    if (r_r == '0) begin
                        r_result[r_v] <= w_s;
                    end
`ifdef EVO_TESTER_UNSTABLE_EN
                    else if (w_s != r_result[r_v]) begin
                        r_unstable[r_v] <= 1'b1;
                    end
`endif
                    if (r_v == c_V_LAST) begin
                        r_v <= '0;
                        if (r_r == c_R_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_r     <= r_r + RW'(1);
                            r_state <= S_APPLY;
                        end
                    end else begin
                        r_v     <= r_v + N_INPUTS'(1);
                        r_state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    // done and the busy fall become visible together.
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_dut_in <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in        = r_dut_in;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error_count   = r_err;
    assign bus.result_tt     = r_result;
`ifdef EVO_TESTER_UNSTABLE_EN
    assign bus.unstable_mask = r_unstable;
`else
    assign bus.unstable_mask = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_evo_circuit_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_evo_circuit_tester
// Description : Directed bench for evo_circuit_tester with a behavioural
//               circuit model (ideal parity / stuck-at-0 / vector-3 flip on
//               odd repeats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evo_circuit_tester;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   mode  = 0;      // 0 parity, 1 stuck-at-0, 2 flip vector 3 on odd repeats
    logic rep_odd = 1'b0;
    logic [2:0] prev_in = 3'd0;

    always #5 clk = ~clk;

    evo_circuit_tester_if #(.N_INPUTS(3), .REPEATS(2)) ifc ();

    evo_circuit_tester #(.N_INPUTS(3), .SETTLE_CYCLES(4), .REPEATS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    // Repeat parity tracker: a fresh pass starts whenever dut_in drops back to 0.
    always @(posedge clk) begin
        prev_in <= ifc.dut_in;
        if (!ifc.busy)
            rep_odd <= 1'b0;
        else if (prev_in != 3'd0 && ifc.dut_in == 3'd0)
            rep_odd <= ~rep_odd;
    end

    assign ifc.dut_out = (mode == 1) ? 1'b0
                       : ((^ifc.dut_in) ^ (mode == 2 && ifc.dut_in == 3'd3 && rep_odd));

    task automatic do_run(input bit hold, output int lat);
        @(negedge clk);
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) ifc.start = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (ifc.done) break;
        end
    endtask

    task automatic test_reset;
        tests++; if (ifc.dut_in !== 3'd0)      begin fails++; $display("FAIL reset_dut_in got %h exp 0", ifc.dut_in); end
        tests++; if (ifc.busy !== 1'b0)        begin fails++; $display("FAIL reset_busy got %b exp 0", ifc.busy); end
        tests++; if (ifc.done !== 1'b0)        begin fails++; $display("FAIL reset_done got %b exp 0", ifc.done); end
        tests++; if (ifc.error_count !== 5'd0) begin fails++; $display("FAIL reset_err got %0d exp 0", ifc.error_count); end
        tests++; if (ifc.result_tt !== 8'h00)  begin fails++; $display("FAIL reset_result got %h exp 00", ifc.result_tt); end
        tests++; if (ifc.unstable_mask !== 8'h00) begin fails++; $display("FAIL reset_unstable got %h exp 00", ifc.unstable_mask); end
    endtask

    task automatic test_parity;
        int lat;
        mode = 0; ifc.expected_tt = 8'h96;
        do_run(1'b0, lat);
        tests++; if (lat != 97)                begin fails++; $display("FAIL parity_latency got %0d exp 97", lat); end
        tests++; if (ifc.error_count !== 5'd0) begin fails++; $display("FAIL parity_err got %0d exp 0", ifc.error_count); end
        tests++; if (ifc.result_tt !== 8'h96)  begin fails++; $display("FAIL parity_result got %h exp 96", ifc.result_tt); end
        tests++; if (ifc.unstable_mask !== 8'h00) begin fails++; $display("FAIL parity_unstable got %h exp 00", ifc.unstable_mask); end
        tests++; if (ifc.busy !== 1'b0)        begin fails++; $display("FAIL parity_busy_at_done got %b exp 0", ifc.busy); end
        tests++; if (ifc.dut_in !== 3'd0)      begin fails++; $display("FAIL parity_dut_in_at_done got %h exp 0", ifc.dut_in); end
        @(posedge clk); #1;
        tests++; if (ifc.done !== 1'b0)        begin fails++; $display("FAIL parity_done_width got %b exp 0", ifc.done); end
    endtask

    task automatic test_stuck0;
        int lat;
        mode = 1; ifc.expected_tt = 8'h96;
        do_run(1'b0, lat);
        tests++; if (ifc.error_count !== 5'd8) begin fails++; $display("FAIL stuck0_err got %0d exp 8", ifc.error_count); end
        tests++; if (ifc.result_tt !== 8'h00)  begin fails++; $display("FAIL stuck0_result got %h exp 00", ifc.result_tt); end
        tests++; if (ifc.unstable_mask !== 8'h00) begin fails++; $display("FAIL stuck0_unstable got %h exp 00", ifc.unstable_mask); end
    endtask

    task automatic test_unstable;
        int lat;
        logic [7:0] exp_mask;
`ifdef EVO_TESTER_UNSTABLE_EN
        exp_mask = 8'h08;
`else
        exp_mask = 8'h00;
`endif
        mode = 2; ifc.expected_tt = 8'h96;
        do_run(1'b0, lat);
        tests++; if (ifc.error_count !== 5'd1) begin fails++; $display("FAIL unstable_err got %0d exp 1", ifc.error_count); end
        tests++; if (ifc.result_tt !== 8'h96)  begin fails++; $display("FAIL unstable_result got %h exp 96", ifc.result_tt); end
        tests++; if (ifc.unstable_mask !== exp_mask) begin fails++; $display("FAIL unstable_mask got %h exp %h", ifc.unstable_mask, exp_mask); end
        mode = 0;
    endtask

    task automatic test_disturb;
        int ndone = 0;
        int first = -1;
        mode = 0; ifc.expected_tt = 8'h96;
        @(negedge clk); ifc.start = 1'b1;
        @(posedge clk); #1; ifc.start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 20) ifc.start = 1'b1;
            if (c == 21) ifc.start = 1'b0;
            if (c == 30) ifc.expected_tt = 8'h00;
            if (ifc.done) begin ndone++; if (first < 0) first = c; end
        end
        tests++; if (ndone != 1)               begin fails++; $display("FAIL disturb_done_count got %0d exp 1", ndone); end
        tests++; if (first != 97)              begin fails++; $display("FAIL disturb_latency got %0d exp 97", first); end
        tests++; if (ifc.error_count !== 5'd0) begin fails++; $display("FAIL disturb_err got %0d exp 0", ifc.error_count); end
        tests++; if (ifc.result_tt !== 8'h96)  begin fails++; $display("FAIL disturb_result got %h exp 96", ifc.result_tt); end
        ifc.expected_tt = 8'h96;
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        int lat;
        mode = 1; ifc.expected_tt = 8'h96;   // stuck model so partial results are nonzero
        @(negedge clk); ifc.start = 1'b1;
        @(posedge clk); #1; ifc.start = 1'b0;
        repeat (32) begin @(posedge clk); #1; end
        tests++; if (ifc.dut_in !== 3'd5)      begin fails++; $display("FAIL rstmid_vector got %h exp 5", ifc.dut_in); end
        tests++; if (ifc.error_count !== 5'd3) begin fails++; $display("FAIL rstmid_partial_err got %0d exp 3", ifc.error_count); end
        reset = 1'b1;
        #1;
        tests++; if ({ifc.dut_in, ifc.busy, ifc.done} !== 5'd0) begin fails++; $display("FAIL rstmid_ctrl got %h exp 0", {ifc.dut_in, ifc.busy, ifc.done}); end
        tests++; if ({ifc.error_count, ifc.result_tt, ifc.unstable_mask} !== 21'd0) begin fails++; $display("FAIL rstmid_results got %h exp 0", {ifc.error_count, ifc.result_tt, ifc.unstable_mask}); end
        @(negedge clk); reset = 1'b0;
        repeat (120) begin @(posedge clk); #1; if (ifc.done) ndone++; end
        tests++; if (ndone != 0)               begin fails++; $display("FAIL rstmid_no_done got %0d exp 0", ndone); end
        mode = 0;
        do_run(1'b0, lat);
        tests++; if (lat != 97)                begin fails++; $display("FAIL rstmid_rerun_latency got %0d exp 97", lat); end
        tests++; if (ifc.result_tt !== 8'h96 || ifc.error_count !== 5'd0) begin fails++; $display("FAIL rstmid_rerun_results got %h/%0d exp 96/0", ifc.result_tt, ifc.error_count); end
    endtask

    task automatic test_start_held;
        int lat;
        int gap = 0;
        mode = 0; ifc.expected_tt = 8'h96;
        do_run(1'b1, lat);
        tests++; if (lat != 97)                begin fails++; $display("FAIL held_first_latency got %0d exp 97", lat); end
        while (gap < 500) begin
            @(posedge clk); #1; gap++;
            if (ifc.done) break;
        end
        ifc.start = 1'b0;
        tests++; if (gap != 98)                begin fails++; $display("FAIL held_period got %0d exp 98", gap); end
        tests++; if (ifc.dut_in !== 3'd0)      begin fails++; $display("FAIL held_dut_in_idle got %h exp 0", ifc.dut_in); end
        repeat (3) begin @(posedge clk); #1; end
        tests++; if (ifc.busy !== 1'b0)        begin fails++; $display("FAIL held_release_busy got %b exp 0", ifc.busy); end
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.expected_tt = 8'h96;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(posedge clk);
        test_parity;
        test_stuck0;
        test_unstable;
        test_disturb;
        test_reset_mid;
        test_start_held;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/evo_circuit_tester.md
# evo_circuit_tester

Sequencer that exercises one evolved combinational circuit (the LCELL/gate-netlist kind, e.g. a 3-input XOR candidate). It drives every input vector in order and waits a programmable settle time. It then samples the circuit output through a synchronizer and compares it against a target truth table. It also accumulates a mismatch count (fitness) over several repeats and flags vectors whose output is not repeatable. It sits between the test host/evaluation logic and the circuit under test.

## Interface
- N_INPUTS, 3: circuit input count; V = 2**N_INPUTS vectors.
- SETTLE_CYCLES, 4: cycles waited after applying a vector before sampling; legal range 2..255.
- REPEATS, 2: full truth-table passes per run; legal range 1..255.
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- expected_tt  input  V  target truth table; bit v = expected output for vector v.
- dut_in  output  N_INPUTS  registered vector driven to the circuit inputs.
- dut_out  input  1  circuit output; asynchronous, 2-flop synchronized internally.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the run completes.
- error_count  output  clog2(REPEATS*V+1)  mismatches in the last run.
- result_tt  output  V  output sampled per vector on repeat 0.
- unstable_mask  output  V  bit v set if any repeat disagreed with result_tt[v].

## Operation
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: if start=1, capture expected_tt into an internal register, clear error_count, result_tt and unstable_mask, set v=0 and r=0, and go to APPLY. A start in any other state is ignored.
- APPLY (1 cycle): dut_in <= v; load the settle counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles): decrement the counter; go to SAMPLE when it reaches 1.
- SAMPLE (1 cycle): compare s = synchronized dut_out with the captured expected bit [v].
  - Mismatch: error_count += 1. error_count cannot overflow by construction of its width.
  - r=0: result_tt[v] <= s.
  - r>0 and s != result_tt[v]: unstable_mask[v] <= 1 (see Configuration).
  - Advance: v = V-1 wraps v to 0 and increments r. Last vector of the last repeat goes to DONE; otherwise go to APPLY.
- DONE (1 cycle): done=1, dut_in <= 0, return to IDLE. Results hold until the next accepted start.
- The comparison uses only the captured expected table, so changes on expected_tt during a run have no effect.

## Timing
- Reset values: dut_in=0, busy=0, done=0, error_count=0, result_tt=0, unstable_mask=0, FSM=IDLE, synchronizer flops=0.
- Per vector: SETTLE_CYCLES+2 cycles. The synchronizer adds 2 cycles, which fall inside the settle window.
- done pulses REPEATS*V*(SETTLE_CYCLES+2)+1 cycles after the edge that accepts start.
- busy falls in the same cycle that done rises. start may be reasserted in the following IDLE cycle, so back-to-back runs are possible.
- Reset asserted mid-run: immediate return to reset values and no done pulse. Partial results are discarded.
- start held high continuously: a new run begins each time the FSM enters IDLE.

## Configuration
- EVO_TESTER_UNSTABLE_EN defined: unstable_mask is tracked as described under SAMPLE.
- Not defined: unstable_mask is tied to 0 and its comparison logic is omitted. error_count, result_tt and timing are unchanged.

## Test plan
- Ideal parity model, expected_tt=8'h96, defaults: error_count=0, result_tt=8'h96, unstable_mask=0, done 97 cycles after start.
- Stuck-at-0 model, expected_tt=8'h96, REPEATS=2: error_count=8, result_tt=8'h00.
- Model that inverts vector 3 on odd repeats, EVO_TESTER_UNSTABLE_EN defined: unstable_mask=8'h08 and error_count=1. Without the macro: unstable_mask=0 and error_count=1.
- start pulsed again while busy, and expected_tt changed to 8'h00 mid-run: single done pulse, results identical to the undisturbed parity run.
- reset asserted during SETTLE of vector 5: all outputs 0 next cycle and no done pulse. A new start then yields a clean 97-cycle run.
- start held high: done pulses every 98 cycles, and dut_in returns to 0 between runs.
